// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: WIDTH x WIDTH shift-and-add multiplier with a start/done handshake
// Ports: clock_i/reset_ni (async active-low); start_i with a_i/b_i operands captured on
// acceptance; busy_o high while running; done_o one-cycle pulse when product_o updates.
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [W2-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d, ext, addend, sum;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, accept, run, last;
  assign accept = (state_q == IDLE) && start_i;
  assign run = (state_q == RUN);
  assign last = run && (cnt_q == CNT_W'(1));
`ifdef SEQ_MULT_SIGNED_EN
  // The multiplier's top bit carries weight -2^(WIDTH-1), so the last partial product is subtracted.
  assign ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign addend = mplier_q[0] ? (last ? -mcand_q : mcand_q) : '0;
`else
  assign ext = {{WIDTH{1'b0}}, a_i};
  assign addend = mplier_q[0] ? mcand_q : '0;
`endif
  assign sum = acc_q + addend;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end
  always_comb begin
    state_d = run ? (last ? IDLE : RUN) : (start_i ? RUN : IDLE);
  end
  always_comb begin
    mcand_d   = accept ? ext : run ? mcand_q << 1 : mcand_q;
    mplier_d  = accept ? b_i : run ? mplier_q >> 1 : mplier_q;
    acc_d     = accept ? '0 : run ? sum : acc_q;
    cnt_d     = accept ? CNT_W'(WIDTH) : run ? cnt_q - CNT_W'(1) : cnt_q;
    product_d = last ? sum : product_q;
    done_d    = last;
  end
  assign busy_o = run;
  assign done_o = done_q;
  assign product_o = product_q;
endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param: randomized self-checking bench for 8- and 16-bit multipliers
module tb_seq_multiplier_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st8 = 1'b0, st16 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  seq_multiplier_param #(.WIDTH(8)) u8 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(st8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .product_o(prod8)
  );
  seq_multiplier_param #(.WIDTH(16)) u16 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(st16), .a_i(a16), .b_i(b16),
    .busy_o(busy16), .done_o(done16), .product_o(prod16)
  );
  function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [15:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    return {8'd0, a} * {8'd0, b};
`endif
  endfunction
  function automatic logic [31:0] model16(logic [15:0] a, logic [15:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    return {16'd0, a} * {16'd0, b};
`endif
  endfunction
  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, output logic [15:0] p,
                      output int lat, output int bcnt);
    @(negedge clk);
    a8 = ai; b8 = bi; st8 = 1'b1; lat = -1; bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      st8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) begin lat = n - 1; break; end
    end
    p = prod8;
  endtask
  task automatic run16(input logic [15:0] ai, input logic [15:0] bi, output logic [31:0] p,
                       output int lat, output int bcnt);
    @(negedge clk);
    a16 = ai; b16 = bi; st16 = 1'b1; lat = -1; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      st16 = 1'b0;
      if (busy16) bcnt++;
      if (done16) begin lat = n - 1; break; end
    end
    p = prod16;
  endtask
  task automatic test_reset();
    vectors++;
    if ({busy8, done8, prod8} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b product=%h, want 0/0/0000", busy8, done8, prod8);
    end
    vectors++;
    if ({busy16, done16, prod16} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset16: busy=%b done=%b product=%h, want 0/0/00000000", busy16, done16, prod16);
    end
  endtask
  task automatic test_basic();
    logic [15:0] p;
    int lat, bc;
    run8(8'd13, 8'd11, p, lat, bc);
    vectors++;
    if (p !== 16'h008F || lat != 8 || bc != 8) begin
      miscompares++;
      $display("FAIL basic_13x11: product=%h lat=%0d busy=%0d, want 008f/8/8", p, lat, bc);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (prod8 !== 16'h008F || done8 !== 1'b0 || busy8 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold: product=%h done=%b busy=%b, want 008f/0/0", prod8, done8, busy8);
    end
  endtask
  task automatic test_corners();
    logic [15:0] p;
    int lat, bc;
    logic [7:0] ca[5] = '{8'd255, 8'd0, 8'hFD, 8'h80, 8'h7F};
    logic [7:0] cb[5] = '{8'd255, 8'd200, 8'd5, 8'h80, 8'hFF};
`ifdef SEQ_MULT_SIGNED_EN
    logic [15:0] ce[5] = '{16'h0001, 16'h0000, 16'hFFF1, 16'h4000, 16'hFF81};
`else
    logic [15:0] ce[5] = '{16'hFE01, 16'h0000, 16'h04F1, 16'h4000, 16'h7E81};
`endif
    for (int i = 0; i < 5; i++) begin
      run8(ca[i], cb[i], p, lat, bc);
      vectors++;
      if (p !== ce[i] || lat != 8) begin
        miscompares++;
        $display("FAIL corner%0d a=%h b=%h: product=%h lat=%0d, want %h/8", i, ca[i], cb[i], p, lat, ce[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    int n, lat;
    @(negedge clk);
    a8 = 8'd13; b8 = 8'd11; st8 = 1'b1;
    n = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      st8 = (n == 2 || n == 5);
      if (st8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      if (done8) begin lat = n - 1; break; end
    end
    vectors++;
    if (prod8 !== 16'h008F || lat != 8) begin
      miscompares++;
      $display("FAIL ignore_start: product=%h lat=%0d, want 008f/8", prod8, lat);
    end
    a8 = 8'd3; b8 = 8'd4; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    vectors++;
    if (busy8 !== 1'b1 || prod8 !== 16'h008F) begin
      miscompares++;
      $display("FAIL done_cycle_start: busy=%b product=%h, want 1/008f", busy8, prod8);
    end
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin lat = k - 1; break; end
    end
    vectors++;
    if (prod8 !== model8(8'd3, 8'd4) || lat != 8) begin
      miscompares++;
      $display("FAIL second_product: product=%h lat=%0d, want 000c/8", prod8, lat);
    end
  endtask
  task automatic test_abort();
    logic [15:0] p;
    int lat, bc, dseen;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_reset: busy=%b done=%b product=%h, want 0/0/0000", busy8, done8, prod8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) dseen++;
    end
    vectors++;
    if (dseen != 0 || prod8 !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_quiet: activity=%0d product=%h, want 0/0000", dseen, prod8);
    end
    run8(8'd7, 8'd9, p, lat, bc);
    vectors++;
    if (p !== 16'd63 || lat != 8 || bc != 8) begin
      miscompares++;
      $display("FAIL after_abort: product=%h lat=%0d busy=%0d, want 003f/8/8", p, lat, bc);
    end
  endtask
  task automatic test_w16();
    logic [31:0] p;
    int lat, bc;
    run16(16'hFFFF, 16'h0002, p, lat, bc);
    vectors++;
`ifdef SEQ_MULT_SIGNED_EN
    if (p !== 32'hFFFFFFFE || lat != 16 || bc != 16) begin
`else
    if (p !== 32'h0001FFFE || lat != 16 || bc != 16) begin
`endif
      miscompares++;
      $display("FAIL w16_ffffx2: product=%h lat=%0d busy=%0d, want %h/16/16", p, lat, bc, model16(16'hFFFF, 16'h2));
    end
  endtask
  task automatic test_random();
    logic [15:0] p8;
    logic [31:0] p16;
    logic [7:0] x8, y8;
    logic [15:0] x16, y16;
    int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom);
      run8(x8, y8, p8, lat, bc);
      vectors++;
      if (p8 !== model8(x8, y8) || lat != 8 || bc != 8) begin
        miscompares++;
        $display("FAIL rand8 a=%h b=%h: product=%h lat=%0d busy=%0d, want %h/8/8", x8, y8, p8, lat, bc, model8(x8, y8));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      x16 = 16'($urandom); y16 = 16'($urandom);
      run16(x16, y16, p16, lat, bc);
      vectors++;
      if (p16 !== model16(x16, y16) || lat != 16 || bc != 16) begin
        miscompares++;
        $display("FAIL rand16 a=%h b=%h: product=%h lat=%0d busy=%0d, want %h/16/16", x16, y16, p16, lat, bc, model16(x16, y16));
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_w16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
